// File: rtl/floo_chan_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : floo_chan_arb_mux
//  Purpose  : Packs up to NumChannels logical AXI channels onto one physical
//             NoC link. Round-robin arbitration over the enabled, valid
//             channels, optional wormhole lock across multi-flit bursts and
//             an optional output register stage.
//  Ports    : clk_i, rst_ni           clock, synchronous active-low reset
//             chan_en_i               runtime per-channel enable mask
//             chan_valid_i/ready_o    per-channel flit handshake
//             chan_data_i             packed payloads, channel i at
//                                     [i*PayloadWidth +: PayloadWidth]
//             chan_last_i             last flit of a burst, per channel
//             valid_o/ready_i         link handshake
//             data_o, chan_id_o       link payload and source channel index
//             last_o                  forwarded last flag
//             locked_o                high while a burst holds the grant
//  Revision : 1.0  initial release
// ============================================================================
module floo_chan_arb_mux #(
    parameter int unsigned NumChannels  = 10,
    parameter int unsigned PayloadWidth = 64,
    parameter int unsigned ChanIdWidth  = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    parameter bit          LockOnBurst  = 1'b1,
    parameter bit          OutReg       = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumChannels-1:0]               chan_en_i,
    input  logic [NumChannels-1:0]               chan_valid_i,
    output logic [NumChannels-1:0]               chan_ready_o,
    input  logic [NumChannels*PayloadWidth-1:0]  chan_data_i,
    input  logic [NumChannels-1:0]               chan_last_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [PayloadWidth-1:0]              data_o,
    output logic [ChanIdWidth-1:0]               chan_id_o,
    output logic                                 last_o,
    output logic                                 locked_o
);

    // One extra bit so pointer + offset can exceed NumChannels-1 before wrap.
    localparam int unsigned c_CandW = ChanIdWidth + 1;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } state_e;

    state_e                   r_state;
    state_e                   w_stateNext;
    logic [ChanIdWidth-1:0]   r_ptr;
    logic [ChanIdWidth-1:0]   r_lockId;
    logic [ChanIdWidth-1:0]   w_arbIdx;
    logic [ChanIdWidth-1:0]   w_grantIdx;
    logic [c_CandW-1:0]       w_cand;
    logic [NumChannels-1:0]   w_req;
    logic                     w_arbFound;
    logic                     w_grantValid;
    logic                     w_grantLast;
    logic                     w_sinkRdy;
    logic                     w_handshake;
    logic [PayloadWidth-1:0]  w_grantData;

    assign w_req = chan_valid_i & chan_en_i;

    // Round-robin pick: first requesting channel at or after the pointer.
    always_comb begin
        w_arbFound = 1'b0;
        w_arbIdx   = '0;
        w_cand     = '0;
        for (int k = 0; k < NumChannels; k++) begin
            w_cand = {1'b0, r_ptr} + c_CandW'(k);
            if (w_cand >= c_CandW'(NumChannels)) begin
                w_cand = w_cand - c_CandW'(NumChannels);
            end
            if (!w_arbFound && w_req[w_cand[ChanIdWidth-1:0]]) begin
                w_arbFound = 1'b1;
                w_arbIdx   = w_cand[ChanIdWidth-1:0];
            end
        end
    end

    // A held burst ignores the enable mask and the pointer entirely, so a
    // channel disabled mid-burst still completes its wormhole. Everything is
    // gated by reset so nothing handshakes while the block is held in reset.
    always_comb begin
        if (r_state == StLocked) begin
            w_grantIdx   = r_lockId;
            w_grantValid = chan_valid_i[r_lockId] & rst_ni;
        end else begin
            w_grantIdx   = w_arbIdx;
            w_grantValid = w_arbFound & rst_ni;
        end
    end

    assign w_grantData = chan_data_i[w_grantIdx*PayloadWidth +: PayloadWidth];
    assign w_grantLast = chan_last_i[w_grantIdx];
    assign w_handshake = w_grantValid & w_sinkRdy;

    always_comb begin
        chan_ready_o             = '0;
        chan_ready_o[w_grantIdx] = w_grantValid & w_sinkRdy;
    end

    generate
        if (NumChannels > 1) begin : g_rrPtr
            logic [ChanIdWidth-1:0] w_ptrNext;
            assign w_ptrNext = (w_grantIdx == ChanIdWidth'(NumChannels - 1))
                             ? '0 : w_grantIdx + 1'b1;
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_ptr <= '0;
                end else if (w_handshake) begin
                    r_ptr <= w_ptrNext;
                end
            end
        end else begin : g_rrPtrTied
            assign r_ptr = '0;
        end
    endgenerate

    // Burst-lock state machine.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_lockId <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_handshake && (r_state == StIdle)) begin
                r_lockId <= w_grantIdx;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            StIdle: begin
                if (LockOnBurst && w_handshake && !w_grantLast) begin
                    w_stateNext = StLocked;
                end
            end
            StLocked: begin
                if (w_handshake && w_grantLast) begin
                    w_stateNext = StIdle;
                end
            end
            default: w_stateNext = StIdle;
        endcase
    end

    assign locked_o = (r_state == StLocked);

    generate
        if (OutReg) begin : g_outReg
            logic                    r_valid;
            logic                    r_last;
            logic [PayloadWidth-1:0] r_data;
            logic [ChanIdWidth-1:0]  r_id;

            // The register accepts a new flit when empty or being drained.
            assign w_sinkRdy = !r_valid | ready_i;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_data  <= '0;
                    r_id    <= '0;
                end else if (w_handshake) begin
                    r_valid <= 1'b1;
                    r_last  <= w_grantLast;
                    r_data  <= w_grantData;
                    r_id    <= w_grantIdx;
                end else if (ready_i) begin
                    r_valid <= 1'b0;
                end
            end

            assign valid_o   = r_valid;
            assign data_o    = r_data;
            assign chan_id_o = r_id;
            assign last_o    = r_last;
        end else begin : g_outComb
            assign w_sinkRdy = ready_i;
            assign valid_o   = w_grantValid;
            assign data_o    = w_grantValid ? w_grantData : '0;
            assign chan_id_o = w_grantValid ? w_grantIdx : '0;
            assign last_o    = w_grantValid & w_grantLast;
        end
    endgenerate

    // Protocol checks.
    generate
        for (genvar i = 0; i < NumChannels; i++) begin : g_inStable
            a_inStable: assert property (@(posedge clk_i) disable iff (!rst_ni)
                ($past(chan_valid_i[i] && !chan_ready_o[i]) && chan_valid_i[i])
                |-> ($stable(chan_data_i[i*PayloadWidth +: PayloadWidth]) &&
                     $stable(chan_last_i[i])));
        end
        if (OutReg) begin : g_validHold
            a_validHold: assert property (@(posedge clk_i) disable iff (!rst_ni)
                (valid_o && !ready_i) |=> valid_o);
        end
    endgenerate

    a_readyOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(chan_ready_o));

endmodule
`default_nettype wire

// File: tb/tb_floo_chan_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_floo_chan_arb_mux
//  Purpose  : Directed bench for floo_chan_arb_mux. DUT A uses the default
//             configuration (burst lock, registered output); DUT B disables
//             the burst lock. Per-channel flit queues act as upstream
//             sources; a transaction-level model of DUT A is compared on
//             every cycle, and hand-computed sequences pin the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_floo_chan_arb_mux;

    localparam int NC = 10;
    localparam int PW = 64;
    localparam int CW = 4;

    logic          clk       = 1'b0;
    logic          rst_ni    = 1'b0;
    logic          ready_i   = 1'b1;
    logic [NC-1:0] chan_en_i = '1;

    logic [NC-1:0]    vld [2];
    logic [NC*PW-1:0] dat [2];
    logic [NC-1:0]    lst [2];
    logic [NC-1:0]    hsPend [2];

    logic [NC-1:0] rdyA, rdyB;
    logic          validA, validB, lastA, lastB, lockedA, lockedB;
    logic [PW-1:0] dataA, dataB;
    logic [CW-1:0] idA, idB;

    // Values applied at the next cycle boundary.
    logic          rstNext   = 1'b0;
    logic          readyNext = 1'b1;
    logic [NC-1:0] enNext    = '1;

    logic [PW:0] srcQ [2][NC][$];

    typedef struct {
        int            id;
        logic [PW-1:0] data;
        bit            locked;
        int            cyc;
    } logEnt_t;
    logEnt_t logA[$];
    int      logB[$];

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;

    // Model of DUT A.
    int            mPtr   = 0;
    int            mLock  = -1;
    logic          mValid = 1'b0;
    logic          mLast  = 1'b0;
    logic [PW-1:0] mData  = '0;
    int            mId    = 0;
    int            mG     = 0;
    bit            mGv    = 1'b0;
    logic [NC-1:0] mExpReady = '0;

    event evCheck;

    floo_chan_arb_mux #(
        .NumChannels(NC), .PayloadWidth(PW), .LockOnBurst(1'b1), .OutReg(1'b1)
    ) u_dutA (
        .clk_i(clk), .rst_ni(rst_ni), .chan_en_i(chan_en_i),
        .chan_valid_i(vld[0]), .chan_ready_o(rdyA), .chan_data_i(dat[0]),
        .chan_last_i(lst[0]), .valid_o(validA), .ready_i(ready_i),
        .data_o(dataA), .chan_id_o(idA), .last_o(lastA), .locked_o(lockedA)
    );

    floo_chan_arb_mux #(
        .NumChannels(NC), .PayloadWidth(PW), .LockOnBurst(1'b0), .OutReg(1'b1)
    ) u_dutB (
        .clk_i(clk), .rst_ni(rst_ni), .chan_en_i(chan_en_i),
        .chan_valid_i(vld[1]), .chan_ready_o(rdyB), .chan_data_i(dat[1]),
        .chan_last_i(lst[1]), .valid_o(validB), .ready_i(ready_i),
        .data_o(dataB), .chan_id_o(idB), .last_o(lastB), .locked_o(lockedB)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    endtask

    task automatic push(input int d, input int ch, input logic [PW-1:0] data, input bit last);
        srcQ[d][ch].push_back({last, data});
    endtask

    // Combinational view of the model for the current inputs.
    function automatic void modelEval();
        mGv = 1'b0;
        mG = 0;
        mExpReady = '0;
        if (!rst_ni) return;
        if (mLock >= 0) begin
            mG  = mLock;
            mGv = vld[0][mLock];
        end else begin
            for (int k = 0; k < NC; k++) begin
                int c = (mPtr + k) % NC;
                if (!mGv && vld[0][c] && chan_en_i[c]) begin
                    mGv = 1'b1;
                    mG  = c;
                end
            end
        end
        if (mGv && (!mValid || ready_i)) mExpReady[mG] = 1'b1;
    endfunction

    function automatic void modelAdvance();
        if (!rst_ni) begin
            mPtr = 0; mLock = -1; mValid = 1'b0; mData = '0; mId = 0; mLast = 1'b0;
        end else if (mExpReady != '0) begin
            mValid = 1'b1;
            mData  = dat[0][mG*PW +: PW];
            mId    = mG;
            mLast  = lst[0][mG];
            mPtr   = (mG + 1) % NC;
            if (mLock < 0 && !mLast) mLock = mG;
            else if (mLock >= 0 && mLast) mLock = -1;
        end else if (ready_i) begin
            mValid = 1'b0;
        end
    endfunction

    // One clock cycle: retire last cycle's handshakes, apply inputs, check.
    task automatic step();
        logic [PW:0] e;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++)
                if (hsPend[d][c] && srcQ[d][c].size() > 0) void'(srcQ[d][c].pop_front());
        rst_ni    = rstNext;
        ready_i   = readyNext;
        chan_en_i = enNext;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                if (srcQ[d][c].size() > 0) begin
                    e = srcQ[d][c][0];
                    vld[d][c] = 1'b1;
                    lst[d][c] = e[PW];
                    dat[d][c*PW +: PW] = e[PW-1:0];
                end else begin
                    vld[d][c] = 1'b0;
                    lst[d][c] = 1'b0;
                    dat[d][c*PW +: PW] = '0;
                end
            end
        end
        #1;
        hsPend[0] = vld[0] & rdyA;
        hsPend[1] = vld[1] & rdyB;
        modelEval();
        -> evCheck;
        #1;
        modelAdvance();
        cyc++;
    endtask

    function automatic bit srcBusy();
        bit b = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++)
                if (srcQ[d][c].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drainAll();
        int n = 0;
        while ((srcBusy() || validA || validB) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            nChecks++;
            $display("FAIL drain_timeout cyc=%0d got=%0d cycles exp=<300", cyc, n);
        end
    endtask

    function automatic logic [63:0] packIdsA();
        logic [63:0] r = '0;
        foreach (logA[i]) r = (r << 4) | 64'(logA[i].id);
        return r;
    endfunction

    function automatic logic [63:0] packIdsB();
        logic [63:0] r = '0;
        foreach (logB[i]) r = (r << 4) | 64'(logB[i]);
        return r;
    endfunction

    function automatic logic [63:0] packDataA();
        logic [63:0] r = '0;
        foreach (logA[i]) r = (r << 16) | 64'(logA[i].data[15:0]);
        return r;
    endfunction

    function automatic int countLockedA();
        int n = 0;
        foreach (logA[i]) if (logA[i].locked) n++;
        return n;
    endfunction

    // Cycle-by-cycle comparison of DUT A against the model, plus output logs.
    always @(evCheck) begin
        check("valid_o", {63'b0, validA}, {63'b0, mValid});
        check("locked_o", {63'b0, lockedA}, {63'b0, (mLock >= 0)});
        check("chan_ready_o", 64'(rdyA), 64'(mExpReady));
        if (mValid) begin
            check("data_o", dataA, mData);
            check("chan_id_o", 64'(idA), 64'(mId));
            check("last_o", {63'b0, lastA}, {63'b0, mLast});
        end
        if (validA && ready_i && rst_ni)
            logA.push_back('{id: int'(idA), data: dataA, locked: lockedA, cyc: cyc});
        if (validB && ready_i && rst_ni)
            logB.push_back(int'(idB));
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            vld[d] = '0; dat[d] = '0; lst[d] = '0; hsPend[d] = '0;
        end

        // Reset with every channel offering a flit.
        for (int c = 0; c < NC; c++) begin
            push(0, c, 64'h100 + 64'(c), 1'b1);
            push(1, c, 64'h100 + 64'(c), 1'b1);
        end
        repeat (3) step();
        check("rst_valid", 64'(validA), 64'h0);
        check("rst_data", dataA, 64'h0);
        check("rst_id", 64'(idA), 64'h0);
        check("rst_last", 64'(lastA), 64'h0);
        check("rst_locked", 64'(lockedA), 64'h0);
        check("rst_ready", 64'(rdyA), 64'h0);
        rstNext = 1'b1;
        step();
        check("first_grant_ready", 64'(rdyA), 64'h1);
        step();
        check("first_valid", 64'(validA), 64'h1);
        check("first_id", 64'(idA), 64'h0);
        check("first_data", dataA, 64'h100);
        drainAll();

        // Round-robin over channels 1, 4, 9 with single-flit bursts.
        logA.delete();
        for (int r = 0; r < 2; r++) begin
            push(0, 1, 64'h110 + 64'(r), 1'b1);
            push(0, 4, 64'h140 + 64'(r), 1'b1);
            push(0, 9, 64'h190 + 64'(r), 1'b1);
        end
        drainAll();
        check("rr_seq", packIdsA(), 64'h149149);
        check("rr_count", 64'(logA.size()), 64'd6);
        check("rr_no_bubble",
              (logA.size() == 6) ? 64'(logA[5].cyc - logA[0].cyc) : 64'hFFFF, 64'd5);

        // Burst lock on ch2 with ch3 competing; DUT B arbitrates per flit.
        logA.delete();
        logB.delete();
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < 4; f++) push(d, 2, 64'h200 + 64'(f), f == 3);
            for (int f = 0; f < 3; f++) push(d, 3, 64'h300 + 64'(f), 1'b1);
        end
        drainAll();
        check("lock_seq", packIdsA(), 64'h2222333);
        check("lock_locked_cnt", 64'(countLockedA()), 64'd3);
        check("nolock_seq", packIdsB(), 64'h2323232);

        // Disabling ch5 mid-burst does not break the lock.
        logA.delete();
        for (int f = 0; f < 3; f++) push(0, 5, 64'h500 + 64'(f), f == 2);
        push(0, 5, 64'h5FF, 1'b1);
        push(0, 6, 64'h600, 1'b1);
        step();
        enNext[5] = 1'b0;
        repeat (5) step();
        check("mask_lock_seq", packIdsA(), 64'h5556);
        check("mask_idle_valid", 64'(validA), 64'h0);
        check("mask_idle_ready", 64'(rdyA), 64'h0);
        enNext = '1;
        drainAll();
        check("mask_release_seq", packIdsA(), 64'h55565);

        // Backpressure on the link.
        logA.delete();
        push(0, 0, 64'hDEAD, 1'b1);
        push(0, 0, 64'hBEEF, 1'b1);
        push(0, 0, 64'hC0DE, 1'b1);
        readyNext = 1'b0;
        repeat (5) step();
        check("bp_valid", 64'(validA), 64'h1);
        check("bp_data", dataA, 64'hDEAD);
        check("bp_ready", 64'(rdyA), 64'h0);
        readyNext = 1'b1;
        step();
        readyNext = 1'b0;
        step();
        check("bp_hold2", dataA, 64'hBEEF);
        readyNext = 1'b1;
        drainAll();
        check("bp_flits", packDataA(), 64'h0000_DEAD_BEEF_C0DE);

        // Reset after the second flit of a 4-flit ch7 burst.
        logA.delete();
        for (int f = 0; f < 4; f++) push(0, 7, 64'h700 + 64'(f), f == 3);
        step();
        step();
        rstNext = 1'b0;
        srcQ[0][7].delete();
        step();
        rstNext = 1'b1;
        push(0, 3, 64'h3A, 1'b1);
        push(0, 8, 64'h8A, 1'b1);
        step();
        check("rstmid_locked", 64'(lockedA), 64'h0);
        check("rstmid_valid", 64'(validA), 64'h0);
        check("rstmid_restart", 64'(rdyA), 64'h8);
        drainAll();
        check("rstmid_seq", packIdsA(), 64'h738);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floo_chan_arb_mux.md
Name: floo_chan_arb_mux

Overview:
- Parametrised N-to-1 channel multiplexer that packs up to NumChannels logical AXI channels onto one physical NoC link (FlooReq, FlooRsp or FlooWide).
- Successor to the fixed compile-time channel-to-link mapping:
  - adds round-robin arbitration;
  - adds runtime channel enable masking;
  - adds burst (wormhole) locking across multi-flit transfers;
  - adds an optional output pipeline register.
- Sits between the chimney's per-channel flit builders and the router input port.

Parameters:
- NumChannels, 10, number of logical input channels (1..16).
- PayloadWidth, 64, flit payload width in bits. Includes rsvd padding; inputs are already padded.
- ChanIdWidth, (NumChannels > 1) ? $clog2(NumChannels) : 1, width of the channel tag.
- LockOnBurst, 1, when 1 the grant is held on a channel until its last flit; when 0, arbitration happens every flit.
- OutReg, 1, when 1 the output is registered (1-cycle latency); when 0 the path is combinational.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- chan_en_i  in  NumChannels  runtime per-channel enable mask.
- chan_valid_i  in  NumChannels  per-channel flit valid.
- chan_ready_o  out  NumChannels  per-channel flit ready.
- chan_data_i  in  NumChannels*PayloadWidth  per-channel payload; channel i occupies bits [i*PayloadWidth +: PayloadWidth].
- chan_last_i  in  NumChannels  last flit of burst.
- valid_o  out  1  link flit valid.
- ready_i  in  1  link ready.
- data_o  out  PayloadWidth  link payload.
- chan_id_o  out  ChanIdWidth  index of the source channel.
- last_o  out  1  last flag forwarded from the source channel.
- locked_o  out  1  high while in a burst lock.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low; all state is updated only on the clk_i rising edge.
- Reset values: valid_o=0, data_o=0, chan_id_o=0, last_o=0, locked_o=0, chan_ready_o=0, RR pointer=0, FSM=Idle.
- Request set: req = chan_valid_i & chan_en_i.
- Round-robin arbitration:
  - Select the first set req bit at index >= ptr, wrapping from NumChannels-1 to 0.
  - After an accepted flit from channel g, ptr <= (g+1) mod NumChannels.
  - ptr is updated only on an input handshake.
- Sink availability: sink_rdy = OutReg ? (!valid_o | ready_i) : ready_i.
- Ready: chan_ready_o[g] = sink_rdy for the granted g only; all other bits are 0. Ready never depends on a channel that is not granted.
- FSM:
  - Idle: arbitrate as above. If a handshake occurs with chan_last_i[g]=0 and LockOnBurst=1, go to Locked(g) and set locked_o=1.
  - Locked(g): grant is forced to g regardless of req, chan_en_i or the RR pointer. Other channels see ready=0.
  - Locked(g) exit: on the handshake with chan_last_i[g]=1, return to Idle, clear locked_o and set ptr=g+1.
  - Clearing chan_en_i[g] while in Locked(g) does NOT break the lock; the mask is applied only in Idle.
- Output with OutReg=1:
  - On an input handshake, load data, chan_id_o=g and last_o, and set valid_o=1.
  - When ready_i=1 and no new handshake, clear valid_o.
  - Full throughput: one flit per cycle under continuous ready_i.
  - data_o, chan_id_o and last_o hold their values while valid_o=1 and ready_i=0.
- Output with OutReg=0: valid_o = |req in Idle, or chan_valid_i[g] in Locked; data is muxed combinationally with zero latency.
- No valid requests: valid_o falls (after draining the register if OutReg=1); ptr and FSM are unchanged.
- Single channel (NumChannels=1): chan_id_o is always 0; the pointer logic is tied off.
- Reset asserted mid-burst: at the next edge, return to Idle, clear the lock and drop any registered flit. There is no partial-burst recovery; upstream is also reset.
- Assertions:
  - chan_data_i and chan_last_i stay stable while valid=1 and ready=0.
  - At most one chan_ready_o bit is set.
  - valid_o is not retracted without ready_i.

Test Plan:
- Reset/idle: hold rst_ni=0 for 3 cycles with every chan_valid_i=1 -> all outputs 0. On release, the first flit comes from ch0 with chan_id_o=0 one cycle later (OutReg=1).
- Round-robin fairness: channels 1, 4 and 9 valid continuously, single-flit bursts (last=1), ready_i=1 -> chan_id_o sequence is 1,4,9,1,4,9, one flit per cycle with no bubbles.
- Burst lock: ch2 sends 4 flits (last on flit 4) while ch3 is valid throughout -> chan_id_o=2,2,2,2 then 3, and locked_o is high for exactly 3 accepted flits. With LockOnBurst=0 the sequence is 2,3,2,3,...
- Mask during lock: mid-burst on ch5, clear chan_en_i[5] -> the burst still completes. The next Idle cycle skips ch5 even though chan_valid_i[5]=1.
- Backpressure: ready_i=0 for 5 cycles with ch0 flit data 0xDEAD -> valid_o=1 and data_o=0xDEAD held stable, chan_ready_o all 0 after the register fills. Lowering ready_i again the cycle after its release -> no flit lost or duplicated.
- Reset mid-burst: assert rst_ni=0 after flit 2 of a 4-flit ch7 burst -> next cycle locked_o=0 and valid_o=0. After release, arbitration restarts at ch0.
